// File: rtl/l2_req_scheduler.sv
// L2 front-end request scheduler: fixed-priority arbitration with CPU aging
// and drain-then-issue flush sequencing into a single registered issue slot.
module l2_req_scheduler #(
  parameter int ADDR_W     = 28,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rsp_valid,
  input  logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_ready,
  input  logic              fwd_valid,
  input  logic [ADDR_W-1:0] fwd_addr,
  input  logic              fwd_stall,
  output logic              fwd_ready,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  input  logic              flush_valid,
  output logic              flush_ready,
  input  logic              pipe_busy,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [1:0]        issue_src,
  output logic [ADDR_W-1:0] issue_addr,
  output logic              flush_done
);

  typedef enum logic [1:0] {
    S_NORMAL,
    S_DRAIN,
    S_FLUSH,
    S_FLWAIT
  } state_e;

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  state_e            state_q, state_d;
  logic              issue_valid_q, issue_valid_d;
  logic [1:0]        issue_src_q, issue_src_d;
  logic [ADDR_W-1:0] issue_addr_q, issue_addr_d;
  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic              flush_done_q, flush_done_d;

  logic load;
  logic starved;
  logic fwd_elig;
  logic grant_rsp, grant_fwd, grant_cpu, grant_flush;

  assign load     = !issue_valid_q || issue_ready;
  assign starved  = (starve_cnt_q == StarveMax);
  assign fwd_elig = fwd_valid && !fwd_stall;

  always_comb begin
    grant_rsp   = 1'b0;
    grant_fwd   = 1'b0;
    grant_cpu   = 1'b0;
    grant_flush = 1'b0;
    unique case (state_q)
      S_NORMAL: begin
        if (load) begin
          if (starved && cpu_valid) grant_cpu = 1'b1;
          else if (rsp_valid)       grant_rsp = 1'b1;
          else if (fwd_elig)        grant_fwd = 1'b1;
          else if (cpu_valid)       grant_cpu = 1'b1;
          else if (flush_valid)     grant_flush = 1'b1;
        end
      end
      S_DRAIN: begin
        if (load) begin
          if (rsp_valid)     grant_rsp = 1'b1;
          else if (fwd_elig) grant_fwd = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Readies are forced low while reset is held.
  assign rsp_ready   = grant_rsp && rst;
  assign fwd_ready   = grant_fwd && rst;
  assign cpu_ready   = grant_cpu && rst;
  assign flush_ready = grant_flush && rst;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!cpu_valid || grant_cpu) begin
      starve_cnt_d = 8'd0;
    end else if ((grant_rsp || grant_fwd) && !starved) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    issue_valid_d = issue_valid_q;
    issue_src_d   = issue_src_q;
    issue_addr_d  = issue_addr_q;
    flush_done_d  = 1'b0;
    unique case (state_q)
      S_NORMAL, S_DRAIN: begin
        if (load) begin
          issue_valid_d = grant_rsp || grant_fwd || grant_cpu;
          unique case (1'b1)
            grant_rsp: begin
              issue_src_d  = 2'd0;
              issue_addr_d = rsp_addr;
            end
            grant_fwd: begin
              issue_src_d  = 2'd1;
              issue_addr_d = fwd_addr;
            end
            grant_cpu: begin
              issue_src_d  = 2'd2;
              issue_addr_d = cpu_addr;
            end
            default: ;
          endcase
        end
        if (grant_flush) state_d = S_DRAIN;
        if (state_q == S_DRAIN && !issue_valid_q && !pipe_busy &&
            !grant_rsp && !grant_fwd) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        issue_valid_d = 1'b1;
        issue_src_d   = 2'd3;
        issue_addr_d  = '0;
        state_d       = S_FLWAIT;
      end
      S_FLWAIT: begin
        if (issue_ready) begin
          issue_valid_d = 1'b0;
          flush_done_d  = 1'b1;
          state_d       = S_NORMAL;
        end
      end
      default: state_d = S_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_NORMAL;
      issue_valid_q <= 1'b0;
      issue_src_q   <= 2'd0;
      issue_addr_q  <= '0;
      starve_cnt_q  <= 8'd0;
      flush_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_valid_q <= issue_valid_d;
      issue_src_q   <= issue_src_d;
      issue_addr_q  <= issue_addr_d;
      starve_cnt_q  <= starve_cnt_d;
      flush_done_q  <= flush_done_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_src   = issue_src_q;
  assign issue_addr  = issue_addr_q;
  assign flush_done  = flush_done_q;

endmodule

// File: tb/tb_l2_req_scheduler.sv
// Bench for l2_req_scheduler: cycle model predicts grants and pushes
// expected issue contents to a scoreboard popped on each issue handshake.
module tb_l2_req_scheduler;

  localparam int AW = 28;

  logic          clk = 1'b0;
  logic          rst;
  logic          rsp_valid, fwd_valid, fwd_stall, cpu_valid, flush_valid;
  logic [AW-1:0] rsp_addr, fwd_addr, cpu_addr;
  logic          rsp_ready, fwd_ready, cpu_ready, flush_ready;
  logic          pipe_busy, issue_valid, issue_ready, flush_done;
  logic [1:0]    issue_src;
  logic [AW-1:0] issue_addr;

  int total = 0;
  int bad   = 0;

  // model state: 0 NORMAL 1 DRAIN 2 FLUSH 3 FLWAIT
  int   m_state;
  int   m_cnt;
  bit   m_iv;
  bit   m_fd;
  logic [AW+1:0] sbq[$];

  always #5 clk = ~clk;

  l2_req_scheduler #(.ADDR_W(AW), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_ready(rsp_ready),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_stall(fwd_stall),
    .fwd_ready(fwd_ready),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .flush_valid(flush_valid), .flush_ready(flush_ready),
    .pipe_busy(pipe_busy),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_src(issue_src), .issue_addr(issue_addr),
    .flush_done(flush_done)
  );

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_iv    = 0;
    m_fd    = 0;
    sbq.delete();
  endtask

  task automatic clear_inputs();
    rsp_valid = 0; fwd_valid = 0; fwd_stall = 0;
    cpu_valid = 0; flush_valid = 0; pipe_busy = 0;
    issue_ready = 0;
    rsp_addr = '0; fwd_addr = '0; cpu_addr = '0;
  endtask

  // One clock: predict, compare at negedge, advance model, return at posedge+1.
  task automatic cyc();
    bit ld;
    int g;
    logic [3:0] exp_rdy, got_rdy;
    logic [AW+1:0] e;
    @(negedge clk);
    ld = !m_iv || issue_ready;
    g = 0;
    if (m_state == 0 && ld) begin
      if (m_cnt == 8 && cpu_valid) g = 3;
      else if (rsp_valid) g = 1;
      else if (fwd_valid && !fwd_stall) g = 2;
      else if (cpu_valid) g = 3;
      else if (flush_valid) g = 4;
    end else if (m_state == 1 && ld) begin
      if (rsp_valid) g = 1;
      else if (fwd_valid && !fwd_stall) g = 2;
    end
    exp_rdy = {g == 1, g == 2, g == 3, g == 4};
    got_rdy = {rsp_ready, fwd_ready, cpu_ready, flush_ready};
    total++;
    if (got_rdy !== exp_rdy) begin
      bad++;
      $display("FAIL readies got=%b exp=%b t=%0t", got_rdy, exp_rdy, $time);
    end
    total++;
    if (issue_valid !== m_iv) begin
      bad++;
      $display("FAIL issue_valid got=%b exp=%b t=%0t", issue_valid, m_iv, $time);
    end
    total++;
    if (flush_done !== m_fd) begin
      bad++;
      $display("FAIL flush_done got=%b exp=%b t=%0t", flush_done, m_fd, $time);
    end
    if (issue_valid === 1'b1 && issue_ready) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_empty got src=%0d addr=%h exp=none", issue_src, issue_addr);
      end else begin
        e = sbq.pop_front();
        if ({issue_src, issue_addr} !== e) begin
          bad++;
          $display("FAIL sb_issue got=%h exp=%h t=%0t", {issue_src, issue_addr}, e, $time);
        end
      end
    end
    // advance model
    m_fd = 0;
    if (!cpu_valid || g == 3) m_cnt = 0;
    else if ((g == 1 || g == 2) && m_cnt < 8) m_cnt++;
    case (m_state)
      0, 1: begin
        if (ld) begin
          m_iv = (g >= 1 && g <= 3);
          if (g == 1) sbq.push_back({2'd0, rsp_addr});
          if (g == 2) sbq.push_back({2'd1, fwd_addr});
          if (g == 3) sbq.push_back({2'd2, cpu_addr});
        end
        if (m_state == 0 && g == 4) m_state = 1;
        else if (m_state == 1 && g == 0 && !ld_prev_iv(ld) && !pipe_busy) m_state = 2;
      end
      2: begin
        m_iv = 1;
        sbq.push_back({2'd3, {AW{1'b0}}});
        m_state = 3;
      end
      default: begin
        if (issue_ready) begin
          m_iv = 0;
          m_fd = 1;
          m_state = 0;
        end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  // DRAIN exit needs the slot empty before this cycle's update.
  bit pre_iv;
  function automatic bit ld_prev_iv(bit unused);
    return pre_iv;
  endfunction

  task automatic step();
    pre_iv = m_iv;
    cyc();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    rsp_valid = 1;
    rsp_addr  = 28'h123;
    #2;
    total++;
    if ({issue_valid, rsp_ready, fwd_ready, cpu_ready, flush_ready, flush_done} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=000000",
        {issue_valid, rsp_ready, fwd_ready, cpu_ready, flush_ready, flush_done});
    end
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    #1;
    total++;
    if (rsp_ready !== 1'b1) begin
      bad++;
      $display("FAIL first_rsp_ready got=%b exp=1", rsp_ready);
    end
    step();
    total++;
    if ({issue_valid, issue_src, issue_addr} !== {1'b1, 2'd0, 28'h123}) begin
      bad++;
      $display("FAIL first_issue got=%b/%0d/%h exp=1/0/123", issue_valid, issue_src, issue_addr);
    end
    rsp_valid = 0;
  endtask

  task automatic test_priority();
    issue_ready = 1;
    rsp_valid = 1; fwd_valid = 1; cpu_valid = 1;
    fwd_addr = 28'h0AA0; cpu_addr = 28'h0CC0;
    for (int i = 0; i < 3; i++) begin
      rsp_addr = 28'h1000 + 28'(i);
      #1;
      total++;
      if ({rsp_ready, fwd_ready, cpu_ready} !== 3'b100) begin
        bad++;
        $display("FAIL prio_rsp got=%b exp=100", {rsp_ready, fwd_ready, cpu_ready});
      end
      step();
    end
    rsp_valid = 0;
    for (int i = 0; i < 2; i++) begin
      fwd_addr = 28'h2000 + 28'(i);
      step();
    end
    fwd_stall = 1;
    #1;
    total++;
    if ({rsp_ready, fwd_ready, cpu_ready} !== 3'b001) begin
      bad++;
      $display("FAIL prio_cpu got=%b exp=001", {rsp_ready, fwd_ready, cpu_ready});
    end
    step();
    total++;
    if (issue_src !== 2'd2) begin
      bad++;
      $display("FAIL prio_cpu_src got=%0d exp=2", issue_src);
    end
    fwd_valid = 0; fwd_stall = 0; cpu_valid = 0;
    step();
  endtask

  task automatic test_starvation();
    issue_ready = 1;
    rsp_valid = 1; cpu_valid = 1;
    cpu_addr = 28'hC0FFEE;
    for (int i = 0; i < 8; i++) begin
      rsp_addr = 28'h3000 + 28'(i);
      #1;
      total++;
      if (rsp_ready !== 1'b1 || cpu_ready !== 1'b0) begin
        bad++;
        $display("FAIL starve_rsp%0d got=%b%b exp=10", i, rsp_ready, cpu_ready);
      end
      step();
    end
    #1;
    total++;
    if (cpu_ready !== 1'b1 || rsp_ready !== 1'b0) begin
      bad++;
      $display("FAIL starve_cpu got=%b%b exp=01", cpu_ready, rsp_ready);
    end
    step();
    total++;
    if (issue_src !== 2'd2 || issue_addr !== 28'hC0FFEE) begin
      bad++;
      $display("FAIL starve_issue got=%0d/%h exp=2/c0ffee", issue_src, issue_addr);
    end
    #1;
    total++;
    if (rsp_ready !== 1'b1) begin
      bad++;
      $display("FAIL starve_cleared got=%b exp=1", rsp_ready);
    end
    step();
    cpu_valid = 0;
  endtask

  task automatic test_backpressure();
    logic [1:0]    s0;
    logic [AW-1:0] a0;
    issue_ready = 0;
    rsp_valid = 1;
    rsp_addr = 28'h4444;
    s0 = issue_src;
    a0 = issue_addr;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({rsp_ready, fwd_ready, cpu_ready, flush_ready} !== 4'b0) begin
        bad++;
        $display("FAIL bp_ready%0d got=%b exp=0000", i,
          {rsp_ready, fwd_ready, cpu_ready, flush_ready});
      end
      step();
    end
    total++;
    if ({issue_valid, issue_src, issue_addr} !== {1'b1, s0, a0}) begin
      bad++;
      $display("FAIL bp_hold got=%0d/%h exp=%0d/%h", issue_src, issue_addr, s0, a0);
    end
    issue_ready = 1;
    #1;
    total++;
    if (rsp_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got=%b exp=1", rsp_ready);
    end
    step();
    total++;
    if (issue_addr !== 28'h4444) begin
      bad++;
      $display("FAIL bp_next got=%h exp=4444", issue_addr);
    end
    rsp_valid = 0;
    step();
  endtask

  task automatic test_flush();
    issue_ready = 1;
    flush_valid = 1;
    pipe_busy = 1;
    #1;
    total++;
    if (flush_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_accept got=%b exp=1", flush_ready);
    end
    step();
    flush_valid = 0;
    cpu_valid = 1;
    cpu_addr = 28'h5555;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (cpu_ready !== 1'b0) begin
        bad++;
        $display("FAIL drain_cpu%0d got=%b exp=0", i, cpu_ready);
      end
      step();
    end
    pipe_busy = 0;
    step();
    step();
    total++;
    if ({issue_valid, issue_src, issue_addr} !== {1'b1, 2'd3, 28'h0}) begin
      bad++;
      $display("FAIL flush_token got=%b/%0d/%h exp=1/3/0", issue_valid, issue_src, issue_addr);
    end
    step();
    total++;
    if (flush_done !== 1'b1 || cpu_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_done_cpu got=%b%b exp=11", flush_done, cpu_ready);
    end
    step();
    cpu_valid = 0;
    step();
  endtask

  task automatic test_reset_flwait();
    issue_ready = 1;
    flush_valid = 1;
    step();
    flush_valid = 0;
    step();
    step();
    issue_ready = 0;
    step();
    total++;
    if (issue_src !== 2'd3 || issue_valid !== 1'b1) begin
      bad++;
      $display("FAIL flwait_setup got=%b/%0d exp=1/3", issue_valid, issue_src);
    end
    #1;
    rst = 0;
    #1;
    total++;
    if ({issue_valid, flush_done} !== 2'b00) begin
      bad++;
      $display("FAIL rst_flwait got=%b exp=00", {issue_valid, flush_done});
    end
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    issue_ready = 1;
    cpu_valid = 1;
    cpu_addr = 28'h6666;
    #1;
    total++;
    if (cpu_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_normal got=%b exp=1", cpu_ready);
    end
    step();
    cpu_valid = 0;
    step();
    step();
  endtask

  initial begin
    model_reset();
    pre_iv = 0;
    test_reset();
    test_priority();
    test_starvation();
    test_backpressure();
    test_flush();
    test_reset_flwait();
    total++;
    if (sbq.size() != (m_iv ? 1 : 0)) begin
      bad++;
      $display("FAIL sb_leftover got=%0d exp=%0d", sbq.size(), m_iv ? 1 : 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
